// File: rtl/alu_pipe.sv
// Operand-latching ALU with a two-stage capture/execute pipeline and a full flag set.
// A, B and the opcode load from a shared bus; i_start launches one operation.
module alu_pipe #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_enable_1,
  input  logic               i_enable_2,
  input  logic               i_enable_3,
  input  logic               i_start,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_carry,
  output logic               o_overflow,
  output logic               o_zero,
  output logic               o_negative,
  output logic               o_valid,
  output logic               o_op_err
);

  localparam int NB_SHAMT = $clog2(NB_DATA);
  localparam int MSB      = NB_DATA - 1;

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SLL = NB_OP'(6'b000000);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] OP_SLT = NB_OP'(6'b101010);

  // Handshake: i_start is a one-cycle strobe with no backpressure; every start
  // is accepted and produces exactly one o_valid pulse two edges later.
  logic [NB_DATA-1:0] a_q, b_q;
  logic [NB_OP-1:0]   op_q;
  logic               s1_valid;
  logic [NB_DATA-1:0] s1_a, s1_b;
  logic [NB_OP-1:0]   s1_op;

  logic [NB_DATA:0]    add_full, sub_full;
  logic [NB_SHAMT-1:0] shamt;
  logic [NB_DATA-1:0]  res;
  logic                carry, ovf, illegal;

  always_comb begin
    add_full = {1'b0, s1_a} + {1'b0, s1_b};
    sub_full = {1'b0, s1_a} - {1'b0, s1_b};
    shamt    = s1_b[NB_SHAMT-1:0];
    res      = '0;
    carry    = 1'b0;
    ovf      = 1'b0;
    illegal  = 1'b0;
    case (s1_op)
      OP_ADD: begin
        res   = add_full[NB_DATA-1:0];
        carry = add_full[NB_DATA];
        ovf   = (s1_a[MSB] == s1_b[MSB]) && (res[MSB] != s1_a[MSB]);
      end
      OP_SUB: begin
        // carry means "no borrow", i.e. A >= B unsigned
        res   = sub_full[NB_DATA-1:0];
        carry = ~sub_full[NB_DATA];
        ovf   = (s1_a[MSB] != s1_b[MSB]) && (res[MSB] != s1_a[MSB]);
      end
      OP_AND:  res = s1_a & s1_b;
      OP_OR:   res = s1_a | s1_b;
      OP_XOR:  res = s1_a ^ s1_b;
      OP_NOR:  res = ~(s1_a | s1_b);
      OP_SLL:  res = s1_a << shamt;
      OP_SRL:  res = s1_a >> shamt;
      OP_SRA:  res = $unsigned($signed(s1_a) >>> shamt);
      OP_SLT:  res = {{(NB_DATA-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_op      <= '0;
      o_data     <= '0;
      o_carry    <= 1'b0;
      o_overflow <= 1'b0;
      o_zero     <= 1'b0;
      o_negative <= 1'b0;
      o_valid    <= 1'b0;
      o_op_err   <= 1'b0;
    end else begin
      if (i_enable_1)      a_q  <= i_data;
      else if (i_enable_2) b_q  <= i_data;
      else if (i_enable_3) op_q <= i_data[NB_DATA-1 -: NB_OP];

      // Stage 1 sees the register values from before any same-cycle load.
      s1_valid <= i_start;
      if (i_start) begin
        s1_a  <= a_q;
        s1_b  <= b_q;
        s1_op <= op_q;
      end

      o_valid <= s1_valid;
      if (s1_valid) begin
        o_data     <= res;
        o_carry    <= carry;
        o_overflow <= ovf;
        o_zero     <= (res == '0);
        o_negative <= res[MSB];
        if (illegal) o_op_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: driver tasks push hand-computed results into a
// scoreboard queue; a negedge monitor pops them as o_valid pulses arrive.
module tb_alu_pipe;

  localparam int W = 13;  // {data[7:0], carry, overflow, zero, negative, op_err}

  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;
  localparam logic [5:0] AND = 6'b100100;
  localparam logic [5:0] SLL = 6'b000000;
  localparam logic [5:0] SRL = 6'b000010;
  localparam logic [5:0] SRA = 6'b000011;
  localparam logic [5:0] SLT = 6'b101010;
  localparam logic [5:0] BAD = 6'b111111;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [7:0] i_data;
  logic       i_enable_1, i_enable_2, i_enable_3, i_start;
  logic [7:0] o_data;
  logic       o_carry, o_overflow, o_zero, o_negative, o_valid, o_op_err;

  logic [W-1:0] exp_q[$];
  int           due_q[$];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_pass = 0;

  alu_pipe #(.NB_DATA(8), .NB_OP(6)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_data(i_data),
    .i_enable_1(i_enable_1), .i_enable_2(i_enable_2), .i_enable_3(i_enable_3),
    .i_start(i_start), .o_data(o_data), .o_carry(o_carry),
    .o_overflow(o_overflow), .o_zero(o_zero), .o_negative(o_negative),
    .o_valid(o_valid), .o_op_err(o_op_err)
  );

  // clock and cycle counter
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] ev(input logic [7:0] d, input logic c, input logic v,
                                      input logic z, input logic n, input logic e);
    return {d, c, v, z, n, e};
  endfunction

  // scoreboard monitor
  always @(negedge i_clk) begin
    if (o_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'(o_valid), 32'd0);
      end else begin
        logic [W-1:0] e;
        int           d;
        e = exp_q.pop_front();
        d = due_q.pop_front();
        check("latency",  cyc,              d);
        check("data",     32'(o_data),      32'(e[12:5]));
        check("carry",    32'(o_carry),     32'(e[4]));
        check("overflow", 32'(o_overflow),  32'(e[3]));
        check("zero",     32'(o_zero),      32'(e[2]));
        check("negative", 32'(o_negative),  32'(e[1]));
        check("op_err",   32'(o_op_err),    32'(e[0]));
      end
    end
  end

  task automatic idle();
    i_enable_1 = 1'b0;
    i_enable_2 = 1'b0;
    i_enable_3 = 1'b0;
    i_start    = 1'b0;
    i_data     = '0;
  endtask

  // en = {enable_1, enable_2, enable_3}; one clock per call
  task automatic drive(input logic [2:0] en, input logic [7:0] d, input logic start,
                       input logic [W-1:0] e);
    i_enable_1 = en[2];
    i_enable_2 = en[1];
    i_enable_3 = en[0];
    i_data     = d;
    i_start    = start;
    if (start) begin
      exp_q.push_back(e);
      due_q.push_back(cyc + 2);
    end
    @(negedge i_clk);
    idle();
  endtask

  task automatic load_a(input logic [7:0] d);  drive(3'b100, d, 1'b0, '0); endtask
  task automatic load_b(input logic [7:0] d);  drive(3'b010, d, 1'b0, '0); endtask
  task automatic load_op(input logic [5:0] op); drive(3'b001, {op, 2'b00}, 1'b0, '0); endtask
  task automatic go(input logic [W-1:0] e);    drive(3'b000, 8'h00, 1'b1, e); endtask

  task automatic drain();
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) begin
      @(negedge i_clk);
      #1;
    end
    check("drain", exp_q.size(), 32'd0);
  endtask

  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                     input logic [W-1:0] e);
    load_a(a);
    load_b(b);
    load_op(op);
    go(e);
    drain();
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_data"},  32'(o_data),     32'd0);
    check({tag, "_flags"}, 32'({o_carry, o_overflow, o_zero, o_negative}), 32'd0);
    check({tag, "_valid"}, 32'(o_valid),    32'd0);
    check({tag, "_err"},   32'(o_op_err),   32'd0);
  endtask

  initial begin
    idle();
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    check_cleared("reset");

    // arithmetic and flags
    run(8'h7F, 8'h01, ADD, ev(8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    run(8'h05, 8'h05, SUB, ev(8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    run(8'h03, 8'h05, SUB, ev(8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    run(8'hFF, 8'h01, ADD, ev(8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));

    // shifts, including upper B bits ignored
    run(8'h90, 8'h03, SRA, ev(8'hF2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    run(8'h90, 8'h03, SRL, ev(8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    run(8'h90, 8'h03, SLL, ev(8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    run(8'h90, 8'hFB, SRL, ev(8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    run(8'h80, 8'h01, SLT, ev(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // back-to-back starts; opcode reloads ride along with each start
    load_a(8'hF0);
    load_b(8'h3C);
    load_op(ADD);
    drive(3'b001, {AND, 2'b00}, 1'b1, ev(8'h2C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    drive(3'b001, {SLT, 2'b00}, 1'b1, ev(8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    go(ev(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    drain();

    // enable priority, then load in the same cycle as start
    drive(3'b110, 8'h22, 1'b0, '0);
    load_op(ADD);
    go(ev(8'h5E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    drive(3'b100, 8'h10, 1'b1, ev(8'h5E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    go(ev(8'h4C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    drain();

    // illegal opcode and sticky error
    load_op(BAD);
    go(ev(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    load_op(ADD);
    go(ev(8'h4C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    drain();

    // reset one cycle after start drops the in-flight op
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    repeat (4) @(negedge i_clk);
    #1;
    check_cleared("mid_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
